// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Round-robin arbitration is selected with MEM_ARB_RR_EN (fixed priority otherwise).
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 5;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/arb2_pick.sv
// Combinational two-way request picker.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the data port always wins.
module arb2_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef MEM_ARB_RR_EN
    input  logic rr_last,
`endif
    output logic winner_c,
    output logic any_req_c
);

    always_comb begin
        any_req_c = req0 | req1;
`ifdef MEM_ARB_RR_EN
        // On a tie, the port that did not win last time goes next
        if (req0 && req1) begin
            winner_c = (rr_last == PORT_DATA) ? PORT_FETCH : PORT_DATA;
        end else begin
            winner_c = req1 ? PORT_DATA : PORT_FETCH;
        end
`else
        winner_c = req1 ? PORT_DATA : PORT_FETCH;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sequencer for the single-port 32x8 memory: one access per 3 cycles.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to the data port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state, state_d;
    logic                cmd_id, cmd_id_d;
    logic                cmd_we, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata, cmd_wdata_d;
    logic                ack0_d, ack1_d, rd_d, wr_d, busy_d;
    logic                winner_c, any_req_c;
`ifdef MEM_ARB_RR_EN
    logic                rr_last, rr_last_d;
`endif

    arb2_pick u_pick (
        .req0      (req0),
        .req1      (req1),
`ifdef MEM_ARB_RR_EN
        .rr_last   (rr_last),
`endif
        .winner_c  (winner_c),
        .any_req_c (any_req_c)
    );

    // Next state, command capture and next values of the registered outputs
    always_comb begin
        state_d     = state;
        cmd_id_d    = cmd_id;
        cmd_we_d    = cmd_we;
        cmd_addr_d  = cmd_addr;
        cmd_wdata_d = cmd_wdata;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        busy_d      = 1'b0;
`ifdef MEM_ARB_RR_EN
        rr_last_d   = rr_last;
`endif
        case (state)
            ST_IDLE: begin
                if (any_req_c) begin
                    state_d     = ST_ISSUE;
                    cmd_id_d    = winner_c;
                    cmd_we_d    = (winner_c == PORT_DATA) ? we1    : we0;
                    cmd_addr_d  = (winner_c == PORT_DATA) ? addr1  : addr0;
                    cmd_wdata_d = (winner_c == PORT_DATA) ? wdata1 : wdata0;
                    rd_d        = !cmd_we_d;
                    wr_d        = cmd_we_d;
                    busy_d      = 1'b1;
`ifdef MEM_ARB_RR_EN
                    rr_last_d   = winner_c;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                busy_d  = 1'b1;
                ack0_d  = (cmd_id == PORT_FETCH);
                ack1_d  = (cmd_id == PORT_DATA);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_id    <= PORT_FETCH;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_last   <= PORT_DATA;
`endif
        end else begin
            state     <= state_d;
            cmd_id    <= cmd_id_d;
            cmd_we    <= cmd_we_d;
            cmd_addr  <= cmd_addr_d;
            cmd_wdata <= cmd_wdata_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            mem_rd    <= rd_d;
            mem_wr    <= wr_d;
            busy      <= busy_d;
`ifdef MEM_ARB_RR_EN
            rr_last   <= rr_last_d;
`endif
        end
    end

    // The command registers drive the memory pins directly; rd/wr strobes qualify them
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    // Memory output is registered, so read data is passed straight through during the ack cycle
    assign rdata = ((ack0 || ack1) && !cmd_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural 32x8 memory behind it.
// Honors MEM_ARB_RR_EN in the reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, mem_rd, mem_wr;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    // Single-port memory with registered read data
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    // Reference model: an access granted at the end of cycle c strobes in c+1, acks in c+2,
    // and the next grant can happen no earlier than the end of cycle c+3.
    int            cyc, free_at, strobe_cyc, ack_cyc;
    logic          p_id, p_we, m_rr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic [DW-1:0] model_mem [32];
    int            nvec, nerr;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic s, a;
        s = (cyc == strobe_cyc);
        a = (cyc == ack_cyc);
        chk("busy",   32'(busy),   32'(s || a));
        chk("mem_rd", 32'(mem_rd), 32'(s && !p_we));
        chk("mem_wr", 32'(mem_wr), 32'(s && p_we));
        chk("ack0",   32'(ack0),   32'(a && p_id == PORT_FETCH));
        chk("ack1",   32'(ack1),   32'(a && p_id == PORT_DATA));
        chk("rdata",  32'(rdata),  (a && !p_we) ? 32'(p_rdata) : 32'd0);
        if (s) begin
            chk("mem_addr", 32'(mem_addr), 32'(p_addr));
            if (p_we) chk("mem_wdata", 32'(mem_wdata), 32'(p_wdata));
        end
        chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
        chk("ack_excl",   32'(ack0 & ack1),     32'd0);
    endtask

    task automatic tick();
        logic w;
        if (rst_n && cyc == strobe_cyc && p_we) model_mem[p_addr] = p_wdata;
        if (rst_n && cyc >= free_at && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
                w = !m_rr;
`else
                w = PORT_DATA;
`endif
            end else begin
                w = req1;
            end
            p_id       = w;
            p_we       = w ? we1 : we0;
            p_addr     = w ? addr1 : addr0;
            p_wdata    = w ? wdata1 : wdata0;
            p_rdata    = p_we ? '0 : model_mem[p_addr];
            strobe_cyc = cyc + 1;
            ack_cyc    = cyc + 2;
            free_at    = cyc + 3;
            m_rr       = w;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic model_reset();
        strobe_cyc = -1;
        ack_cyc    = -1;
        free_at    = 0;
        m_rr       = PORT_DATA;
    endtask

    task automatic run_access(input vec_t v);
        bit got;
        got = 1'b0;
        if (v.port) begin req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
        else        begin req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if ((v.port && ack1) || (!v.port && ack0)) begin
                got = 1'b1;
                chk("tbl_rdata", 32'(rdata), 32'(v.exp_rdata));
                if (v.port) req1 = 1'b0; else req0 = 1'b0;
            end
        end
        if (!got) begin
            chk("tbl_ack_timeout", 32'd0, 32'd1);
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    task automatic rand_port(input logic p, inout logic r, inout logic w,
                             inout logic [AW-1:0] a, inout logic [DW-1:0] d);
        if (r && cyc == ack_cyc && p_id == p) begin
            if ($urandom_range(3) == 0) begin
                w = 1'($urandom_range(1)); a = AW'($urandom); d = DW'($urandom);
            end else begin
                r = 1'b0;
            end
        end else if (r && cyc == strobe_cyc && p_id == p) begin
            w = 1'($urandom_range(1)); a = AW'($urandom); d = DW'($urandom);
        end else if (!r && $urandom_range(2) == 0) begin
            r = 1'b1; w = 1'($urandom_range(1)); a = AW'($urandom); d = DW'($urandom);
        end else if (r && $urandom_range(7) == 0) begin
            a = AW'($urandom);
        end
    endtask

    initial begin
        int   grants[$];
        logic exp_g[4];
        bit   done;

        nvec = 0; nerr = 0; cyc = 0;
        model_reset();
        for (int i = 0; i < 32; i++) begin mem[i] = '0; model_mem[i] = '0; end
        mem_rdata = '0;
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

        tbl[0] = '{1'b1, 1'b1, 5'd3,  8'hA5, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'hA5};
        tbl[2] = '{1'b1, 1'b1, 5'd0,  8'h5C, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 5'd31, 8'hFF, 8'h00};
        tbl[4] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hFF};
        tbl[5] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h5C};
        tbl[6] = '{1'b0, 1'b1, 5'd7,  8'h77, 8'h00};
        tbl[7] = '{1'b1, 1'b1, 5'd9,  8'h99, 8'h00};
        tbl[8] = '{1'b1, 1'b0, 5'd7,  8'h00, 8'h77};
        tbl[9] = '{1'b0, 1'b0, 5'd9,  8'h00, 8'h99};

        // Power-on reset
        tick();
        tick();
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed single-port accesses, including the addr 31 / addr 0 boundaries
        foreach (tbl[i]) begin
            run_access(tbl[i]);
            tick();
        end

        // Address change while granted must not affect the access
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd7; wdata0 = '0;
        done = 1'b0;
        for (int k = 0; k < 6 && !done; k++) begin
            tick();
            if (cyc == strobe_cyc) done = 1'b1;
        end
        chk("frz_reached_issue", 32'(done), 32'd1);
        chk("frz_mem_addr", 32'(mem_addr), 32'd7);
        addr0 = 5'd9;
        tick();
        chk("frz_ack0",  32'(ack0),  32'd1);
        chk("frz_rdata", 32'(rdata), 32'h77);
        req0 = 1'b0;
        tick();
        tick();

        // Reset in the middle of an ISSUE cycle abandons the access
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
        done = 1'b0;
        for (int k = 0; k < 6 && !done; k++) begin
            tick();
            if (cyc == strobe_cyc) done = 1'b1;
        end
        chk("mid_reached_issue", 32'(done), 32'd1);
        rst_n = 1'b0;
        req0 = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_busy",   32'(busy),      32'd0);
        chk("mid_rst_rd",     32'(mem_rd),    32'd0);
        chk("mid_rst_wr",     32'(mem_wr),    32'd0);
        chk("mid_rst_ack",    32'({ack0, ack1}), 32'd0);
        chk("mid_rst_addr",   32'(mem_addr),  32'd0);
        chk("mid_rst_wdata",  32'(mem_wdata), 32'd0);
        chk("mid_rst_rdata",  32'(rdata),     32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_ack", 32'({ack0, ack1}), 32'd0);
        end

        // Both ports held high for four reads: tie-break order
`ifdef MEM_ARB_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd31;
        for (int k = 0; k < 20 && grants.size() < 4; k++) begin
            tick();
            if (ack0) grants.push_back(0);
            if (ack1) grants.push_back(1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("tie_count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            chk("tie_grant", 32'(grants[k]), 32'(exp_g[k]));
        tick();
        tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            tick();
            rand_port(PORT_FETCH, req0, we0, addr0, wdata0);
            rand_port(PORT_DATA,  req1, we1, addr1, wdata1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
